// File: rtl/ani_seq_ctrl.sv
// Animation sequencer: four debounced buttons select the animation and frame period;
// a period timer drives frame tick/wrap. Autoplay is built only when ANI_AUTOPLAY_EN is defined.
module ani_seq_ctrl #(
    parameter int NUM_ANI     = 12,
    parameter int DEB_CYCLES  = 512,
    parameter int PERIOD_RST  = 10_000_000,
    parameter int PERIOD_STEP = 1_000_000,
    parameter int PERIOD_MIN  = 1_000_000,
    parameter int PERIOD_MAX  = 20_000_000,
    parameter int AUTO_LOOPS  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_next,
    input  logic        btn_prev,
    input  logic        btn_faster,
    input  logic        btn_slower,
    input  logic        auto_en,
    input  logic [4:0]  frame_limit,
    output logic [3:0]  anim,
    output logic [4:0]  frame,
    output logic [23:0] period,
    output logic        tick,
    output logic        wrap
);

    // The period register is 24 bits, so the upper clamp cannot exceed 2^24-1.
    localparam logic [24:0] P_LIMIT  = 25'h0FF_FFFF;
    localparam logic [24:0] P_MAX    = (25'(PERIOD_MAX) > P_LIMIT) ? P_LIMIT : 25'(PERIOD_MAX);
    localparam logic [24:0] P_MIN    = 25'(PERIOD_MIN);
    localparam logic [24:0] P_STEP   = 25'(PERIOD_STEP);
    localparam logic [23:0] P_RST    = 24'(PERIOD_RST);
    localparam logic [11:0] DEB_HIT  = 12'(DEB_CYCLES - 1);
    localparam logic [3:0]  ANI_LAST = 4'(NUM_ANI - 1);

    typedef enum logic {MANUAL, AUTO} state_t;

    state_t      state, state_nxt;
    logic [3:0]  btn;
    logic [3:0]  press;
    logic [11:0] deb_cnt [4];
    logic [23:0] timer;
    logic        expire, last_frame, auto_adv;
    logic        want_next, go_next, go_prev, go_fast, go_slow, anim_chg;
    logic [3:0]  anim_inc, anim_dec;
    logic [24:0] p_sum;
    logic [23:0] p_fast, p_slow;

    assign btn = {btn_slower, btn_faster, btn_prev, btn_next};

    for (genvar i = 0; i < 4; i++) begin : g_deb
        always_ff @(posedge clk) begin
            if (reset || !btn[i])
                deb_cnt[i] <= '0;
            else if (deb_cnt[i] != 12'hFFF)
                deb_cnt[i] <= deb_cnt[i] + 12'd1;
        end
        // Fires on the DEB_CYCLES-th consecutive high cycle only.
        assign press[i] = btn[i] && (deb_cnt[i] == DEB_HIT);
    end

    assign expire     = ({1'b0, timer} + 25'd1) >= {1'b0, period};
    assign last_frame = frame >= frame_limit;

    // Autoplay advance behaves exactly like a next press; conflicting pairs cancel.
    assign want_next = press[0] || auto_adv;
    assign go_next   = want_next && !press[1];
    assign go_prev   = press[1] && !want_next;
    assign go_fast   = press[2] && !press[3];
    assign go_slow   = press[3] && !press[2];
    assign anim_chg  = go_next || go_prev;

    assign anim_inc = (anim >= ANI_LAST) ? 4'd0 : anim + 4'd1;
    assign anim_dec = (anim == 4'd0) ? ANI_LAST : anim - 4'd1;

    assign p_fast = ({1'b0, period} >= P_MIN + P_STEP) ? 24'({1'b0, period} - P_STEP) : P_MIN[23:0];
    assign p_sum  = {1'b0, period} + P_STEP;
    assign p_slow = (p_sum >= P_MAX) ? P_MAX[23:0] : p_sum[23:0];

`ifdef ANI_AUTOPLAY_EN
    localparam int LW = (AUTO_LOOPS > 1) ? $clog2(AUTO_LOOPS) : 1;
    localparam logic [LW-1:0] LOOP_LAST = LW'(AUTO_LOOPS - 1);

    logic [LW-1:0] loop_cnt;

    always_ff @(posedge clk) begin
        if (reset || state == MANUAL || anim_chg)
            loop_cnt <= '0;
        else if (expire && last_frame)
            loop_cnt <= (loop_cnt == LOOP_LAST) ? '0 : loop_cnt + 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= MANUAL;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        auto_adv  = 1'b0;
`ifdef ANI_AUTOPLAY_EN
        case (state)
            MANUAL: if (auto_en) state_nxt = AUTO;
            AUTO: begin
                if (!auto_en) state_nxt = MANUAL;
                // The final wrap of the loop is consumed by the advance itself.
                auto_adv = expire && last_frame && (loop_cnt == LOOP_LAST);
            end
            default: state_nxt = MANUAL;
        endcase
`else
        state_nxt = MANUAL;
`endif
    end

`ifndef ANI_AUTOPLAY_EN
    logic unused_cfg;
    assign unused_cfg = ^{auto_en, state};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            anim   <= '0;
            frame  <= '0;
            period <= P_RST;
            timer  <= '0;
            tick   <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            tick <= 1'b0;
            wrap <= 1'b0;
            if (go_fast)
                period <= p_fast;
            else if (go_slow)
                period <= p_slow;

            // An animation change outranks a coincident timer expiry.
            if (anim_chg) begin
                anim  <= go_next ? anim_inc : anim_dec;
                frame <= '0;
                timer <= '0;
            end else if (expire) begin
                timer <= '0;
                tick  <= 1'b1;
                if (last_frame) begin
                    frame <= '0;
                    wrap  <= 1'b1;
                end else begin
                    frame <= frame + 5'd1;
                end
            end else begin
                timer <= timer + 24'd1;
            end
        end
    end

endmodule

// File: tb/tb_ani_seq_ctrl.sv
// Bench for ani_seq_ctrl: press table, hand-written timing sequences and a randomized
// run against a behavioural model; autoplay checks follow ANI_AUTOPLAY_EN.
module tb_ani_seq_ctrl;

    localparam int NUM_ANI = 12, DEB = 4, P_RST = 10, P_STEP = 2, P_MIN = 2, P_MAX = 20, LOOPS = 2;

    logic        clk = 1'b0;
    logic        reset, btn_next, btn_prev, btn_faster, btn_slower, auto_en;
    logic [4:0]  frame_limit;
    logic [3:0]  anim;
    logic [4:0]  frame;
    logic [23:0] period;
    logic        tick, wrap;

    int total = 0;
    int bad   = 0;

    ani_seq_ctrl #(
        .NUM_ANI(NUM_ANI), .DEB_CYCLES(DEB), .PERIOD_RST(P_RST), .PERIOD_STEP(P_STEP),
        .PERIOD_MIN(P_MIN), .PERIOD_MAX(P_MAX), .AUTO_LOOPS(LOOPS)
    ) dut (
        .clk(clk), .reset(reset), .btn_next(btn_next), .btn_prev(btn_prev),
        .btn_faster(btn_faster), .btn_slower(btn_slower), .auto_en(auto_en),
        .frame_limit(frame_limit), .anim(anim), .frame(frame), .period(period),
        .tick(tick), .wrap(wrap)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    int m_held [4];
    int m_anim, m_frame, m_period, m_timer;
    bit m_tick, m_wrap;
`ifdef ANI_AUTOPLAY_EN
    int m_loops;
    bit m_auto;
`endif

    task automatic model_step();
        bit [3:0] b, pr;
        bit expire, lastf, adv, up, dn, chg;
        b = {btn_slower, btn_faster, btn_prev, btn_next};
        if (reset) begin
            for (int i = 0; i < 4; i++) m_held[i] = 0;
            m_anim = 0; m_frame = 0; m_period = P_RST; m_timer = 0; m_tick = 0; m_wrap = 0;
`ifdef ANI_AUTOPLAY_EN
            m_loops = 0; m_auto = 0;
`endif
            return;
        end
        for (int i = 0; i < 4; i++) begin
            pr[i] = b[i] && (m_held[i] == DEB - 1);
            m_held[i] = b[i] ? ((m_held[i] < 4095) ? m_held[i] + 1 : 4095) : 0;
        end
        expire = (m_timer >= m_period - 1);
        lastf  = (m_frame >= int'(frame_limit));
        adv    = 0;
`ifdef ANI_AUTOPLAY_EN
        adv = m_auto && expire && lastf && (m_loops == LOOPS - 1);
`endif
        up = pr[0] || adv;
        dn = pr[1];
        chg = (up != dn);
        m_tick = 0;
        m_wrap = 0;
        if (chg) begin
            m_anim  = up ? (m_anim + 1) % NUM_ANI : (m_anim + NUM_ANI - 1) % NUM_ANI;
            m_frame = 0;
            m_timer = 0;
        end else if (expire) begin
            m_timer = 0;
            m_tick  = 1;
            if (lastf) begin
                m_frame = 0;
                m_wrap  = 1;
            end else begin
                m_frame = m_frame + 1;
            end
        end else begin
            m_timer = m_timer + 1;
        end
        if (pr[2] && !pr[3])
            m_period = (m_period - P_STEP < P_MIN) ? P_MIN : m_period - P_STEP;
        else if (pr[3] && !pr[2])
            m_period = (m_period + P_STEP > P_MAX) ? P_MAX : m_period + P_STEP;
`ifdef ANI_AUTOPLAY_EN
        if (!m_auto || chg) m_loops = 0;
        else if (expire && lastf) m_loops = (m_loops + 1) % LOOPS;
        m_auto = auto_en;
`endif
    endtask

    // Model advances with the inputs the DUT is about to sample; outputs are read 1 unit after the edge.
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_model(input string nm);
        chk(nm, {anim, frame, period, tick, wrap},
            {4'(m_anim), 5'(m_frame), 24'(m_period), m_tick, m_wrap});
    endtask

    task automatic set_btn(input logic [3:0] v);
        {btn_slower, btn_faster, btn_prev, btn_next} = v;
    endtask

    typedef struct {
        logic [3:0]  btn;
        int          hold;
        logic [3:0]  exp_anim;
        logic [23:0] exp_period;
    } vec_t;

    vec_t tv [22];

    initial begin
        logic [4:0] ef;
        logic       et, ew;

        tv[0] = '{4'b0001, 3,  4'd0,  24'd10};
        tv[1] = '{4'b0001, 20, 4'd1,  24'd10};
        tv[2] = '{4'b0010, 5,  4'd0,  24'd10};
        tv[3] = '{4'b0010, 4,  4'd11, 24'd10};
        tv[4] = '{4'b0001, 6,  4'd0,  24'd10};
        tv[5] = '{4'b0011, 6,  4'd0,  24'd10};
        for (int k = 0; k < 5; k++)
            tv[6 + k] = '{4'b0100, 5, 4'd0, 24'((k < 4) ? 8 - 2 * k : 2)};
        for (int k = 0; k < 10; k++)
            tv[11 + k] = '{4'b1000, 5, 4'd0, 24'((k < 9) ? 4 + 2 * k : 20)};
        tv[21] = '{4'b1100, 6, 4'd0, 24'd20};

        reset = 1'b1; auto_en = 1'b0; frame_limit = 5'd3;
        set_btn(4'b0000);
        repeat (3) cyc();
        chk("rst_anim", anim, 0);
        chk("rst_frame", frame, 0);
        chk("rst_period", period, 10);
        chk("rst_tick", tick, 0);
        chk("rst_wrap", wrap, 0);
        reset = 1'b0;

        // Button press table
        foreach (tv[i]) begin
            set_btn(tv[i].btn);
            repeat (tv[i].hold) cyc();
            set_btn(4'b0000);
            repeat (2) cyc();
            chk($sformatf("tv%0d_anim", i), anim, tv[i].exp_anim);
            chk($sformatf("tv%0d_period", i), period, tv[i].exp_period);
        end

        // Frame cadence: tick every 10 cycles, frames 1,2,3,0 with wrap on 3->0
        reset = 1'b1; cyc(); reset = 1'b0;
        frame_limit = 5'd3;
        for (int k = 1; k <= 40; k++) begin
            cyc();
            et = (k % 10 == 0);
            ef = 5'((k / 10) % 4);
            ew = et && (ef == 5'd0);
            chk($sformatf("cadence_k%0d", k), {frame, tick, wrap}, {ef, et, ew});
        end

        // Next press landing on the timer expiry edge
        reset = 1'b1; cyc(); reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            btn_next = (k >= 7);
            cyc();
            chk($sformatf("collide_tick_k%0d", k), tick, 0);
        end
        chk("collide_anim", anim, 1);
        chk("collide_frame", frame, 0);
        btn_next = 1'b0;
        for (int k = 11; k <= 20; k++) begin
            cyc();
            chk($sformatf("after_collide_tick_k%0d", k), tick, (k == 20));
        end
        chk("after_collide_frame", frame, 1);

        // Reset in the middle of a period
        btn_faster = 1'b1; repeat (4) cyc(); btn_faster = 1'b0;
        repeat (3) cyc();
        chk("pre_rst_period", period, 8);
        reset = 1'b1; cyc();
        chk("midrst_state", {anim, frame, period, tick, wrap}, {4'd0, 5'd0, 24'd10, 1'b0, 1'b0});
        reset = 1'b0;

        // Press held through reset must be re-debounced after release
        btn_next = 1'b1;
        repeat (2) cyc();
        reset = 1'b1; cyc(); reset = 1'b0;
        repeat (3) cyc();
        chk("held_rst_early", anim, 0);
        cyc();
        chk("held_rst_event", anim, 1);
        btn_next = 1'b0;
        cyc();

        // Autoplay
        reset = 1'b1; cyc(); reset = 1'b0;
        frame_limit = 5'd1; auto_en = 1'b1;
        for (int k = 1; k <= 120; k++) begin
            cyc();
`ifdef ANI_AUTOPLAY_EN
            chk($sformatf("auto_anim_k%0d", k), anim, 4'(k / 40));
`else
            chk($sformatf("noauto_anim_k%0d", k), anim, 0);
`endif
        end
        auto_en = 1'b0;
        for (int k = 0; k < 100; k++) begin
            cyc();
`ifdef ANI_AUTOPLAY_EN
            chk($sformatf("auto_hold_k%0d", k), anim, 3);
`else
            chk($sformatf("noauto_hold_k%0d", k), anim, 0);
`endif
        end

        // Randomized run against the model
        chk_model("model_sync");
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 7) == 0) btn_next   = ~btn_next;
            if ($urandom_range(0, 7) == 0) btn_prev   = ~btn_prev;
            if ($urandom_range(0, 7) == 0) btn_faster = ~btn_faster;
            if ($urandom_range(0, 7) == 0) btn_slower = ~btn_slower;
            if ($urandom_range(0, 199) == 0) frame_limit = 5'($urandom_range(0, 5));
            if ($urandom_range(0, 299) == 0) auto_en = ~auto_en;
            reset = ($urandom_range(0, 799) == 0);
            cyc();
            chk_model($sformatf("rand_n%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
